div_issue_ctrl: RTL and testbench

//  Stream front-end for the fixed-latency signed divider. Accepts operand pairs on a

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_result_fifo.sv | 77 +++++++
 rtl/div_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_div_issue_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue front-end.
// Result entry layout and the signed overflow operand live here.
package div_pkg;

    localparam int DIV_DATA_LEN = 32;
    localparam int DIV_LATENCY  = 11;
    localparam int DIV_TAG_LEN  = 4;

    typedef struct packed {
        logic [DIV_DATA_LEN-1:0] data;
        logic [DIV_TAG_LEN-1:0]  tag;
        logic                    dbz;
        logic                    ovf;
    } div_result_t;

    function automatic logic [DIV_DATA_LEN-1:0] div_int_min();
        return {1'b1, {(DIV_DATA_LEN-1){1'b0}}};
    endfunction

endpackage

// File: rtl/div_result_fifo.sv
// Show-ahead result FIFO; head entry is visible whenever non-empty.
// Upstream credits guarantee a push never lands on a full FIFO.
module div_result_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  div_result_t   i_data,
    input  logic          i_pop,
    output div_result_t   o_data,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam logic [AW-1:0] L_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] L_FULL = CW'(DEPTH);

    div_result_t   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_full    = (r_count == L_FULL);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage write; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap at DEPTH so non power-of-two depths work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overrun: assert property (
        @(posedge clk) disable iff (reset) !(i_push && w_full)
    );

endmodule

// File: rtl/div_issue_ctrl.sv
// Valid/ready front-end for the fixed-latency signed divider.
// Tracks ops in a delay line and buffers quotients under credit control.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int DATA_LEN   = DIV_DATA_LEN,
    parameter int LATENCY    = DIV_LATENCY,
    parameter int FIFO_DEPTH = 16,
    parameter int TAG_LEN    = DIV_TAG_LEN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_a,
    input  logic [DATA_LEN-1:0] in_b,
    input  logic [TAG_LEN-1:0]  in_tag,
    output logic [DATA_LEN-1:0] div_a,
    output logic [DATA_LEN-1:0] div_b,
    input  logic [DATA_LEN-1:0] div_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data,
    output logic [TAG_LEN-1:0]  out_tag,
    output logic                out_dbz,
    output logic                out_ovf
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] L_DEPTH = FIFO_DEPTH[CW:0];

    logic                r_live;
    logic [CW-1:0]       r_inflight;
    logic [DATA_LEN-1:0] r_div_a;
    logic [DATA_LEN-1:0] r_div_b;
    logic                r_vld [LATENCY+1];
    logic [TAG_LEN-1:0]  r_tag [LATENCY+1];
    logic                r_dbz [LATENCY+1];
    logic                r_ovf [LATENCY+1];

    logic          w_accept;
    logic          w_release;
    logic          w_in_dbz;
    logic          w_in_ovf;
    logic          w_push;
    logic          w_empty;
    logic [CW-1:0] w_fifo_count;
    logic [CW:0]   w_used;
    div_result_t   w_push_entry;
    div_result_t   w_head;

    assign w_accept  = in_valid & in_ready;
    assign w_release = out_valid & out_ready;
    assign w_in_dbz  = (in_b == '0);
    assign w_in_ovf  = (in_a == div_int_min()) && (in_b == '1);

    // Every accepted op reserves a FIFO slot until it is released.
    assign w_used   = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign in_ready = r_live & (w_used != L_DEPTH);

    assign w_push = r_vld[LATENCY];
    assign w_push_entry = '{
        data: r_dbz[LATENCY] ? '0 : div_result,
        tag:  r_tag[LATENCY],
        dbz:  r_dbz[LATENCY],
        ovf:  r_ovf[LATENCY]
    };

    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign out_valid = ~w_empty;
    assign out_data  = w_head.data;
    assign out_tag   = w_head.tag;
    assign out_dbz   = w_head.dbz;
    assign out_ovf   = w_head.ovf;

    // Readiness is withheld until the first clock after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Operand capture; illegal divisors become 1 to keep the divider X-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_a <= '0;
            r_div_b <= '0;
        end else if (w_accept) begin
            r_div_a <= in_a;
            r_div_b <= (w_in_dbz | w_in_ovf) ? DATA_LEN'(1) : in_b;
        end
    end

    // Valid bits of the delay line, aligned with div_result at the last stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= LATENCY; i++) begin
                r_vld[i] <= 1'b0;
            end
        end else begin
            r_vld[0] <= w_accept;
            for (int i = 1; i <= LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Delay-line payload; only meaningful where the matching valid is set.
    always_ff @(posedge clk) begin
        r_tag[0] <= in_tag;
        r_dbz[0] <= w_in_dbz;
        r_ovf[0] <= w_in_ovf;
        for (int i = 1; i <= LATENCY; i++) begin
            r_tag[i] <= r_tag[i-1];
            r_dbz[i] <= r_dbz[i-1];
            r_ovf[i] <= r_ovf[i-1];
        end
    end

    // In-flight count: accepted ops not yet pushed into the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            unique case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    div_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_release),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural 11-cycle divider.
// Driver queues expected results on accept; a monitor checks each release.
module tb_div_issue_ctrl;
    import div_pkg::*;

    localparam int DL  = 32;
    localparam int LAT = 11;
    localparam int FD  = 16;
    localparam int TL  = 4;
    localparam logic [DL-1:0] IMIN = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DL-1:0] in_a = '0;
    logic [DL-1:0] in_b = '0;
    logic [TL-1:0] in_tag = '0;
    logic [DL-1:0] div_a;
    logic [DL-1:0] div_b;
    logic [DL-1:0] div_result;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DL-1:0] out_data;
    logic [TL-1:0] out_tag;
    logic          out_dbz;
    logic          out_ovf;

    always #5 clk = ~clk;

    div_issue_ctrl #(
        .DATA_LEN(DL), .LATENCY(LAT), .FIFO_DEPTH(FD), .TAG_LEN(TL)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .div_a(div_a), .div_b(div_b), .div_result(div_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag),
        .out_dbz(out_dbz), .out_ovf(out_ovf)
    );

    // Behavioural divider: LAT register stages, truncating signed quotient.
    function automatic logic [DL-1:0] qdiv(input logic [DL-1:0] a, input logic [DL-1:0] b);
        logic signed [DL-1:0] sa;
        logic signed [DL-1:0] sb;
        sa = a;
        sb = b;
        if (b == '0) return '0;
        if (a == IMIN && b == '1) return IMIN;
        return sa / sb;
    endfunction

    logic [DL-1:0] pipe [LAT];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= qdiv(div_a, div_b);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign div_result = pipe[LAT-1];

    typedef struct {
        logic [DL-1:0] data;
        logic [TL-1:0] tag;
        logic          dbz;
        logic          ovf;
        int            acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_chk = 0;
    int   cyc = 0;
    bit   lat_exact = 0;
    bit   rnd_rdy = 0;
    int   max_q = 0;
    int   pop_cnt = 0;
    int   last_pop = 0;
    int   first_pop = 0;
    int   mark = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tally(input bit ok, input string msg);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s", msg);
    endtask

    // Monitor: compare each released head against the scoreboard.
    exp_t          m_e;
    int            m_lat;
    bit            m_ok;
    bit            hold_prev = 0;
    logic [DL-1:0] p_data;
    logic [TL-1:0] p_tag;
    logic          p_dbz;
    logic          p_ovf;

    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 0;
        end else begin
            if (sb_q.size() > max_q) max_q = sb_q.size();
            if (hold_prev) begin
                tally(out_valid && out_data == p_data && out_tag == p_tag &&
                      out_dbz == p_dbz && out_ovf == p_ovf,
                      $sformatf("hold got v=%b d=%h t=%h exp d=%h t=%h",
                                out_valid, out_data, out_tag, p_data, p_tag));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    tally(0, $sformatf("unexpected got d=%h t=%h exp none",
                                       out_data, out_tag));
                end else begin
                    m_e = sb_q.pop_front();
                    m_lat = cyc - m_e.acc;
                    m_ok = (out_data == m_e.data) && (out_tag == m_e.tag) &&
                           (out_dbz == m_e.dbz) && (out_ovf == m_e.ovf) &&
                           (lat_exact ? (m_lat == LAT + 2) : (m_lat >= LAT + 2));
                    tally(m_ok, $sformatf(
                        "result got d=%h t=%h z=%b o=%b lat=%0d exp d=%h t=%h z=%b o=%b lat=%0d",
                        out_data, out_tag, out_dbz, out_ovf, m_lat,
                        m_e.data, m_e.tag, m_e.dbz, m_e.ovf, LAT + 2));
                    pop_cnt++;
                    last_pop = cyc;
                    if (pop_cnt == mark) first_pop = cyc;
                end
            end
            hold_prev = out_valid && !out_ready;
            p_data = out_data;
            p_tag = out_tag;
            p_dbz = out_dbz;
            p_ovf = out_ovf;
        end
    end

    // Random consumer backpressure when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [DL-1:0] a, input logic [DL-1:0] b,
                        input logic [TL-1:0] t, input logic [DL-1:0] ed,
                        input logic ez, input logic eo,
                        input int budget, output bit ok);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = t;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back('{ed, t, ez, eo, cyc});
                ok = 1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
    endtask

    task automatic model(input logic [DL-1:0] a, input logic [DL-1:0] b,
                         output logic [DL-1:0] d, output logic z, output logic o);
        logic signed [DL-1:0] sa;
        logic signed [DL-1:0] sb;
        sa = a;
        sb = b;
        z = (b == '0);
        o = (a == IMIN) && (b == 32'hFFFF_FFFF);
        if (z) d = '0;
        else if (o) d = IMIN;
        else d = sa / sb;
    endtask

    task automatic send_r(input logic [DL-1:0] a, input logic [DL-1:0] b,
                          input logic [TL-1:0] t);
        bit            ok;
        logic [DL-1:0] d;
        logic          z;
        logic          o;
        model(a, b, d, z, o);
        send(a, b, t, d, z, o, 300, ok);
        if (!ok) tally(0, $sformatf("accept got timeout exp in_ready a=%h", a));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (sb_q.size() == 0) break;
        end
        tally(sb_q.size() == 0,
              $sformatf("%s drain got %0d pending exp 0", name, sb_q.size()));
    endtask

    function automatic logic [DL-1:0] rnd_b();
        int r;
        r = $urandom_range(0, 20);
        if ($urandom_range(0, 1) == 1) return DL'($urandom());
        return DL'(r - 10);
    endfunction

    initial begin
        bit ok;
        int n;
        int c0;
        int base;
        logic [DL-1:0] a;
        logic [DL-1:0] b;

        repeat (3) @(posedge clk);
        #1;
        tally(out_valid == 0, $sformatf("rst out_valid got %b exp 0", out_valid));
        tally(in_ready == 0, $sformatf("rst in_ready got %b exp 0", in_ready));
        tally(div_a == 0 && div_b == 0,
              $sformatf("rst div got %h/%h exp 0/0", div_a, div_b));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        tally(in_ready == 1, $sformatf("post-rst in_ready got %b exp 1", in_ready));

        lat_exact = 1;
        send(100, 7, 4'd3, 14, 0, 0, 20, ok);
        tally(ok, "t1 accept got timeout exp accept");
        idle();
        drain(40, "t1");

        send(32'hFFFF_FFF9, 2, 4'd1, 32'hFFFF_FFFD, 0, 0, 20, ok);
        send(5, 0, 4'd2, 0, 1, 0, 20, ok);
        tally(div_a == 5 && div_b == 1,
              $sformatf("dbz div got %h/%h exp 5/1", div_a, div_b));
        send(IMIN, 32'hFFFF_FFFF, 4'd4, IMIN, 0, 1, 20, ok);
        tally(div_a == IMIN && div_b == 1,
              $sformatf("ovf div got %h/%h exp %h/1", div_a, div_b, IMIN));
        send(9, 3, 4'd5, 3, 0, 0, 20, ok);
        idle();
        repeat (4) @(posedge clk);
        #1;
        tally(div_a == 9 && div_b == 3,
              $sformatf("div hold got %h/%h exp 9/3", div_a, div_b));
        drain(40, "t2");
        lat_exact = 0;

        base = pop_cnt;
        mark = pop_cnt + 1;
        c0 = cyc;
        for (int i = 0; i < 200; i++) begin
            send_r($urandom(), rnd_b(), 4'($urandom()));
        end
        tally(cyc - c0 == 200, $sformatf("t3 burst cycles got %0d exp 200", cyc - c0));
        idle();
        drain(60, "t3");
        tally(pop_cnt - base == 200 && last_pop - first_pop == 199,
              $sformatf("t3 rate got %0d in %0d exp 200 in 199",
                        pop_cnt - base, last_pop - first_pop));

        out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 17; i++) begin
            model(DL'(i * 37), DL'(i + 1), a, ok, ok);
            send(DL'(i * 37), DL'(i + 1), 4'(i), a, 0, 0, 40, ok);
            if (ok) n++;
        end
        idle();
        tally(n == 16, $sformatf("t4 accepts got %0d exp 16", n));
        tally(in_ready == 0, $sformatf("t4 in_ready got %b exp 0", in_ready));
        tally(out_valid == 1, $sformatf("t4 out_valid got %b exp 1", out_valid));
        out_ready = 1'b1;
        drain(60, "t4");

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_r(DL'(1000 + i), 3, 4'(i));
        idle();
        repeat (15) @(posedge clk);
        for (int i = 0; i < 5; i++) send_r(DL'(2000 + i), 7, 4'(i + 8));
        idle();
        #1;
        reset = 1'b1;
        #1;
        tally(out_valid == 0, $sformatf("t5 rst out_valid got %b exp 0", out_valid));
        tally(in_ready == 0, $sformatf("t5 rst in_ready got %b exp 0", in_ready));
        sb_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tally(in_ready == 1, $sformatf("t5 in_ready got %b exp 1", in_ready));
        repeat (30) @(posedge clk);
        #1;
        tally(out_valid == 0, $sformatf("t5 stale out_valid got %b exp 0", out_valid));

        max_q = 0;
        rnd_rdy = 1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                idle();
                @(posedge clk);
                #1;
            end
            n = $urandom_range(0, 15);
            if (n == 0) begin
                a = $urandom();
                b = '0;
            end else if (n == 1) begin
                a = IMIN;
                b = 32'hFFFF_FFFF;
            end else begin
                a = $urandom();
                b = rnd_b();
            end
            send_r(a, b, 4'($urandom()));
        end
        idle();
        rnd_rdy = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain(100, "t6");
        tally(max_q <= FD, $sformatf("t6 outstanding got %0d exp <=%0d", max_q, FD));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
